// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC and fetch-stage controller for the five-stage pipeline
// Optional performance counters are enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          LOAD_STALL   = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        LoadUse,
  input  logic        IMemReady,
  input  logic        Halt,
  output logic [31:0] Address,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        AlignErr,
  output logic        Halted,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);

  logic [1:0]  state, next_state;
  logic [2:0]  cnt, next_cnt;
  logic        set_align;
  logic        redirect, misaligned;
  logic [31:0] target, seq_addr;

  assign redirect   = Jump | BranchTaken;
  assign target     = Jump ? JumpTarget : BranchTarget;
  assign misaligned = |target[1:0];
  assign seq_addr   = PCResult + 32'd4;

  always_comb begin
    Address     = seq_addr;
    PC_Write    = 1'b0;
    IFID_Write  = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    Halted      = 1'b0;
    next_state  = S_RUN;
    next_cnt    = 3'd0;
    set_align   = 1'b0;
    if (!Reset) begin
      Address     = RESET_VECTOR;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (state == S_HALT) begin
      Halted      = 1'b1;
      IDEX_Bubble = 1'b1;
      next_state  = S_HALT;
    end else if (state == S_RUN && Halt) begin
      next_state = S_HALT;
    end else if (redirect) begin
      // A redirect abandons the in-flight fetch and any pending stall.
      IFID_Write = 1'b1;
      IFID_Flush = 1'b1;
      if (misaligned) begin
        set_align  = 1'b1;
        next_state = S_HALT;
      end else begin
        Address  = target;
        PC_Write = 1'b1;
      end
    end else if (state == S_STALL) begin
      IDEX_Bubble = 1'b1;
      next_cnt    = cnt - 3'd1;
      next_state  = (cnt <= 3'd1) ? S_RUN : S_STALL;
    end else if (LoadUse) begin
      IDEX_Bubble = 1'b1;
      if (LOAD_STALL > 1) begin
        next_cnt   = STALL_RELOAD;
        next_state = S_STALL;
      end
    end else if (!IMemReady) begin
      IFID_Write = 1'b1;
      IFID_Flush = 1'b1;
    end else begin
      PC_Write   = 1'b1;
      IFID_Write = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_RUN;
      cnt      <= 3'd0;
      AlignErr <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      AlignErr <= AlignErr | set_align;
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (!PC_Write && state != S_HALT && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (IFID_Flush && flush_q != 32'hFFFF_FFFF)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign StallCycles = stall_q;
  assign FlushCount  = flush_q;
`else
  assign StallCycles = 32'd0;
  assign FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
// Directed scenarios plus randomized traffic against a behavioural reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          LS = 3;
`ifdef PC_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] pc_reg;
  logic        BranchTaken, Jump, LoadUse, IMemReady, Halt;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] Address, StallCycles, FlushCount;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, AlignErr, Halted;

  int errors = 0;
  int checks = 0;

  // reference model: remaining hold cycles, halted flag, sticky error, event counts
  int          m_hold;
  bit          m_halt, m_align;
  int unsigned m_stall, m_flush;
  int          n_hold;
  bit          n_halt, n_align;
  logic        e_pcw, e_ifw, e_flush, e_bub, e_halt;
  logic [31:0] e_addr;

  always #5 Clk = ~Clk;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) pc_reg <= RV;
    else if (PC_Write) pc_reg <= Address;
  end

  pc_sequencer #(.RESET_VECTOR(RV), .LOAD_STALL(LS)) dut (
    .Clk(Clk), .Reset(Reset), .PCResult(pc_reg),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .LoadUse(LoadUse),
    .IMemReady(IMemReady), .Halt(Halt), .Address(Address),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .AlignErr(AlignErr), .Halted(Halted),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  task automatic model_clear;
    m_hold = 0; m_halt = 0; m_align = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_eval;
    logic        redir;
    logic [31:0] tgt;
    redir = Jump | BranchTaken;
    tgt   = Jump ? JumpTarget : BranchTarget;
    {e_pcw, e_ifw, e_flush, e_bub, e_halt} = '0;
    e_addr = pc_reg + 32'd4;
    n_hold = m_hold; n_halt = m_halt; n_align = m_align;
    if (!Reset) begin
      e_addr = RV; e_flush = 1; e_bub = 1;
    end else if (m_halt) begin
      e_halt = 1; e_bub = 1;
    end else if (m_hold == 0 && Halt) begin
      n_halt = 1;
    end else if (redir) begin
      e_ifw = 1; e_flush = 1; n_hold = 0;
      if (tgt % 4 != 0) begin
        n_align = 1; n_halt = 1;
      end else begin
        e_pcw = 1; e_addr = tgt;
      end
    end else if (m_hold > 0) begin
      e_bub = 1; n_hold = m_hold - 1;
    end else if (LoadUse) begin
      e_bub = 1; n_hold = LS - 1;
    end else if (!IMemReady) begin
      e_ifw = 1; e_flush = 1;
    end else begin
      e_pcw = 1; e_ifw = 1;
    end
  endtask

  task automatic advance;
    model_eval();
    @(posedge Clk);
    if (!Reset) model_clear();
    else begin
      if (!e_pcw && !m_halt) m_stall++;
      if (e_flush) m_flush++;
      m_hold = n_hold; m_halt = n_halt; m_align = n_align;
    end
    #1;
  endtask

  task automatic set_idle;
    BranchTaken = 0; Jump = 0; LoadUse = 0; IMemReady = 1; Halt = 0;
    BranchTarget = 32'h0; JumpTarget = 32'h0;
  endtask

  task automatic do_reset;
    set_idle();
    Reset = 0;
    model_clear();
    repeat (2) begin @(posedge Clk); #1; end
    Reset = 1;
  endtask

  task automatic test_reset;
    set_idle();
    Reset = 0;
    model_clear();
    #2;
    checks++;
    if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Halted, AlignErr} !== 6'b001100) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 001100",
               {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Halted, AlignErr});
    end
    checks++;
    if (Address !== RV) begin errors++; $display("FAIL reset_addr: got %h want %h", Address, RV); end
    checks++;
    if ({StallCycles, FlushCount} !== 64'd0) begin
      errors++; $display("FAIL reset_counters: got %h/%h want 0/0", StallCycles, FlushCount);
    end
    @(posedge Clk); #1;
    Reset = 1;
  endtask

  task automatic test_seq_fetch;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_idle();
      #4;
      checks++;
      if (PC_Write !== 1'b1 || Address !== RV + 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: got pcw=%b addr=%h want pcw=1 addr=%h", i, PC_Write, Address, RV + 32'(4 * i));
      end
      advance();
    end
  endtask

  task automatic test_branch_vs_loaduse;
    do_reset();
    BranchTaken = 1; BranchTarget = 32'h40; LoadUse = 1;
    #4;
    checks++;
    if (Address !== 32'h40 || {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble} !== 4'b1110) begin
      errors++;
      $display("FAIL branch_vs_loaduse: got addr=%h ctrl=%b want addr=40 ctrl=1110",
               Address, {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble});
    end
    advance();
    set_idle();
    #4;
    checks++;
    if (FlushCount !== (PERF ? 32'd1 : 32'd0)) begin
      errors++; $display("FAIL flush_count: got %0d want %0d", FlushCount, PERF ? 1 : 0);
    end
    advance();
  endtask

  task automatic test_long_stall;
    do_reset();
    set_idle();
    advance();
    for (int i = 0; i < LS; i++) begin
      set_idle();
      LoadUse = (i != 1);
      #4;
      checks++;
      if (PC_Write !== 1'b0 || IDEX_Bubble !== 1'b1) begin
        errors++; $display("FAIL load_stall[%0d]: got pcw=%b bubble=%b want 0/1", i, PC_Write, IDEX_Bubble);
      end
      advance();
    end
    set_idle();
    #4;
    checks++;
    if (PC_Write !== 1'b1 || Address !== RV + 32'd8 || IDEX_Bubble !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume: got pcw=%b addr=%h bubble=%b want 1/%h/0", PC_Write, Address, IDEX_Bubble, RV + 32'd8);
    end
    checks++;
    if (StallCycles !== (PERF ? 32'(LS) : 32'd0)) begin
      errors++; $display("FAIL stall_cycles: got %0d want %0d", StallCycles, PERF ? LS : 0);
    end
    advance();
  endtask

  task automatic test_mem_wait_jump;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      IMemReady = 0;
      #4;
      checks++;
      if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble} !== 4'b0110) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b want 0110", i, {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble});
      end
      advance();
    end
    IMemReady = 0; Jump = 1; JumpTarget = 32'h100; BranchTaken = 1; BranchTarget = 32'h200;
    #4;
    checks++;
    if (PC_Write !== 1'b1 || Address !== 32'h100) begin
      errors++; $display("FAIL wait_jump: got pcw=%b addr=%h want 1/00000100", PC_Write, Address);
    end
    advance();
    set_idle();
    #4;
    checks++;
    if (Address !== 32'h104) begin errors++; $display("FAIL after_jump: got %h want 00000104", Address); end
    advance();
  endtask

  task automatic test_misaligned;
    do_reset();
    BranchTaken = 1; BranchTarget = 32'h42;
    #4;
    checks++;
    if (PC_Write !== 1'b0) begin errors++; $display("FAIL misaligned_pcw: got %b want 0", PC_Write); end
    advance();
    for (int i = 0; i < 3; i++) begin
      set_idle();
      Jump = 1; JumpTarget = 32'h80; LoadUse = (i == 1);
      #4;
      checks++;
      if ({Halted, AlignErr, PC_Write, IFID_Write, IDEX_Bubble} !== 5'b11001) begin
        errors++;
        $display("FAIL halted[%0d]: got %b want 11001", i, {Halted, AlignErr, PC_Write, IFID_Write, IDEX_Bubble});
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    LoadUse = 1;
    advance();
    set_idle();
    #2;
    Reset = 0;
    model_clear();
    #1;
    checks++;
    if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Halted} !== 5'b00110 || Address !== RV) begin
      errors++;
      $display("FAIL mid_stall_reset: got ctrl=%b addr=%h want 00110/%h",
               {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Halted}, Address, RV);
    end
    @(posedge Clk); #1;
    Reset = 1;
    for (int i = 1; i <= 2; i++) begin
      #4;
      checks++;
      if (PC_Write !== 1'b1 || IDEX_Bubble !== 1'b0 || Address !== RV + 32'(4 * i)) begin
        errors++;
        $display("FAIL post_reset_run[%0d]: got pcw=%b bubble=%b addr=%h want 1/0/%h",
                 i, PC_Write, IDEX_Bubble, Address, RV + 32'(4 * i));
      end
      advance();
    end
  endtask

  task automatic test_random;
    logic [31:0] t;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      Reset       = ($urandom_range(0, 49) != 0);
      Halt        = ($urandom_range(0, 39) == 0);
      Jump        = ($urandom_range(0, 9) == 0);
      BranchTaken = ($urandom_range(0, 7) == 0);
      LoadUse     = ($urandom_range(0, 4) == 0);
      IMemReady   = ($urandom_range(0, 3) != 0);
      t = $urandom() & ~32'h3;
      if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
      BranchTarget = t;
      JumpTarget   = $urandom() & ~32'h3;
      if (!Reset) model_clear();
      #4;
      model_eval();
      checks++;
      if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Halted, AlignErr} !==
          {e_pcw, e_ifw, e_flush, e_bub, e_halt, m_align}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
                 {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Halted, AlignErr},
                 {e_pcw, e_ifw, e_flush, e_bub, e_halt, m_align});
      end
      if (e_pcw || !Reset) begin
        checks++;
        if (Address !== e_addr) begin
          errors++; $display("FAIL rand_addr[%0d]: got %h want %h", i, Address, e_addr);
        end
      end
      checks++;
      if (StallCycles !== (PERF ? m_stall : 32'd0) || FlushCount !== (PERF ? m_flush : 32'd0)) begin
        errors++;
        $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", i, StallCycles, FlushCount,
                 PERF ? m_stall : 0, PERF ? m_flush : 0);
      end
      advance();
    end
  endtask

  initial begin
    set_idle();
    Reset = 0;
    model_clear();
    #1;
    test_reset();
    test_seq_fetch();
    test_branch_vs_loaduse();
    test_long_stall();
    test_mem_wait_jump();
    test_misaligned();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
